// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl
//   Sequencer for one external Montgomery multiplier (64-bit operands, GO /
//   is_ready handshake). Computes result = x_in ^ e_in mod m_in with
//   left-to-right square-and-multiply:
//     XB  = MM(X, R2)            base into Montgomery domain
//     ACC = MM(1, R2) = R mod M  Montgomery "one"
//     for each exponent bit, MSB first: ACC = MM(ACC, ACC);
//                                       if bit set: ACC = MM(ACC, XB)
//     result = MM(ACC, 1)        back out of Montgomery domain
//   Every multiplier op is followed by exactly one cycle with mm_go low so
//   the multiplier clears before the next op.
//
// Optional feature (macro MOD_EXP_SKIP_LEADING_ZEROS_EN):
//   when defined, the bit index starts at the highest set bit of E instead
//   of EXP_W-1, and E = 0 skips the squaring loop entirely. When undefined,
//   all EXP_W bits are always processed (constant time w.r.t. the exponent
//   length).
//
// Ports:
//   pclk, reset   clock, synchronous active-high reset
//   start         one-cycle request, operands sampled when idle
//   x_in, e_in    base (< M) and exponent (EXP_W bits)
//   m_in, r2_in   odd modulus > 1 and R^2 mod M (R = 2^64)
//   busy, done    busy from the cycle after accept until done; done pulse
//   result        X^E mod M, held until overwritten by the next operation
//   mm_go/mm_a/mm_b/mm_m  multiplier request, operands and latched modulus
//   mm_p, mm_ready        multiplier product (bits 65:64 unused) and ready

module mod_exp_ctrl #(
  parameter int EXP_W = 64
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      x_in,
  input  logic [EXP_W-1:0] e_in,
  input  logic [63:0]      m_in,
  input  logic [63:0]      r2_in,
  output logic             busy,
  output logic             done,
  output logic [63:0]      result,
  output logic             mm_go,
  output logic [63:0]      mm_a,
  output logic [63:0]      mm_b,
  output logic [63:0]      mm_m,
  input  logic [65:0]      mm_p,
  input  logic             mm_ready
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_X, S_PRE_A, S_SQR, S_MUL, S_POST, S_GAP, S_DONE
  } state_t;

  state_t           r_state, w_state_next;
  state_t           r_ret, w_ret_next;        // state to enter after GAP
  logic [63:0]      r_x, w_x_next;
  logic [63:0]      r_r2, w_r2_next;
  logic [EXP_W-1:0] r_e, w_e_next;
  logic [63:0]      r_m, w_m_next;
  logic [63:0]      r_xb, w_xb_next;
  logic [63:0]      r_acc, w_acc_next;
  logic [63:0]      r_result, w_result_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;

  // The multiplier's two extra product bits are intentionally ignored.
  logic w_unused_p;
  assign w_unused_p = ^mm_p[65:64];

`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
  // Priority search for the highest set exponent bit; it settles while the
  // PRE_X/PRE_A ops run, so loading it at PRE_A completion costs no cycles.
  logic [IDX_W-1:0] w_msb;
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < EXP_W; i++) begin
      if (r_e[i]) w_msb = IDX_W'(i);
    end
  end
`endif

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ret    <= S_IDLE;
      r_x      <= '0;
      r_r2     <= '0;
      r_e      <= '0;
      r_m      <= '0;
      r_xb     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ret    <= w_ret_next;
      r_x      <= w_x_next;
      r_r2     <= w_r2_next;
      r_e      <= w_e_next;
      r_m      <= w_m_next;
      r_xb     <= w_xb_next;
      r_acc    <= w_acc_next;
      r_result <= w_result_next;
      r_idx    <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_ret_next    = r_ret;
    w_x_next      = r_x;
    w_r2_next     = r_r2;
    w_e_next      = r_e;
    w_m_next      = r_m;
    w_xb_next     = r_xb;
    w_acc_next    = r_acc;
    w_result_next = r_result;
    w_idx_next    = r_idx;
    busy          = 1'b0;
    done          = 1'b0;
    mm_go         = 1'b0;
    mm_a          = '0;
    mm_b          = '0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_x_next     = x_in;
          w_e_next     = e_in;
          w_m_next     = m_in;
          w_r2_next    = r2_in;
          w_idx_next   = IDX_TOP;
          w_state_next = S_PRE_X;
        end
      end

      S_PRE_X: begin
        busy  = 1'b1;
        mm_go = 1'b1;
        mm_a  = r_x;
        mm_b  = r_r2;
        if (mm_ready) begin
          w_xb_next    = mm_p[63:0];
          w_ret_next   = S_PRE_A;
          w_state_next = S_GAP;
        end
      end

      S_PRE_A: begin
        busy  = 1'b1;
        mm_go = 1'b1;
        mm_a  = 64'd1;
        mm_b  = r_r2;
        if (mm_ready) begin
          w_acc_next   = mm_p[63:0];
          w_state_next = S_GAP;
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
          if (r_e == '0) begin
            w_ret_next = S_POST;
          end else begin
            w_idx_next = w_msb;
            w_ret_next = S_SQR;
          end
`else
          w_ret_next = S_SQR;
`endif
        end
      end

      S_SQR: begin
        busy  = 1'b1;
        mm_go = 1'b1;
        mm_a  = r_acc;
        mm_b  = r_acc;
        if (mm_ready) begin
          w_acc_next   = mm_p[63:0];
          w_state_next = S_GAP;
          // The index only moves on once the current bit is fully handled,
          // so a set bit keeps it for the following MUL.
          if (r_e[r_idx]) begin
            w_ret_next = S_MUL;
          end else if (r_idx == '0) begin
            w_ret_next = S_POST;
          end else begin
            w_idx_next = r_idx - IDX_W'(1);
            w_ret_next = S_SQR;
          end
        end
      end

      S_MUL: begin
        busy  = 1'b1;
        mm_go = 1'b1;
        mm_a  = r_acc;
        mm_b  = r_xb;
        if (mm_ready) begin
          w_acc_next   = mm_p[63:0];
          w_state_next = S_GAP;
          if (r_idx == '0) begin
            w_ret_next = S_POST;
          end else begin
            w_idx_next = r_idx - IDX_W'(1);
            w_ret_next = S_SQR;
          end
        end
      end

      S_POST: begin
        busy  = 1'b1;
        mm_go = 1'b1;
        mm_a  = r_acc;
        mm_b  = 64'd1;
        if (mm_ready) begin
          w_result_next = mm_p[63:0];
          w_ret_next    = S_DONE;
          w_state_next  = S_GAP;
        end
      end

      S_GAP: begin
        // mm_go low for this single cycle clears the multiplier.
        busy         = 1'b1;
        w_state_next = r_ret;
      end

      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign result = r_result;
  assign mm_m   = r_m;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
module tb_mod_exp_ctrl;
  localparam int EXP_W = 8;

  logic             pclk = 1'b0;
  logic             reset;
  logic             start;
  logic [63:0]      x_in, m_in, r2_in;
  logic [EXP_W-1:0] e_in;
  logic             busy, done;
  logic [63:0]      result;
  logic             mm_go;
  logic [63:0]      mm_a, mm_b, mm_m;
  logic [65:0]      mm_p = '0;
  logic             mm_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int fixed_lat = 0;          // 0: random multiplier latency per op
  int lat_cnt = 0, lat_cur = 1;
  int prot_err = 0;
  int go_edges = 0;
  logic        prev_go = 1'b0, prev_ready = 1'b0, in_op = 1'b0;
  logic [63:0] prev_a = '0, prev_b = '0;
  int          gap = 0;
  logic [63:0] exp_m = '0;

  always #5 pclk = ~pclk;

  mod_exp_ctrl #(.EXP_W(EXP_W)) dut (
    .pclk(pclk), .reset(reset), .start(start),
    .x_in(x_in), .e_in(e_in), .m_in(m_in), .r2_in(r2_in),
    .busy(busy), .done(done), .result(result),
    .mm_go(mm_go), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_p(mm_p), .mm_ready(mm_ready)
  );

  // Bit-serial Montgomery product a*b*2^-64 mod m (the multiplier model).
  function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] m);
    logic [65:0] t;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[63:0];
  endfunction

  // 2^128 mod m by repeated doubling.
  function automatic logic [63:0] r2_of(input logic [63:0] m);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 0; i < 128; i++) r = (r << 1) % {64'd0, m};
    return r[63:0];
  endfunction

  // Reference: right-to-left binary exponentiation with plain arithmetic.
  function automatic logic [63:0] ref_exp(input logic [63:0] x, input logic [EXP_W-1:0] e,
                                          input logic [63:0] m);
    logic [127:0] base, res, mm;
    logic [EXP_W-1:0] ee;
    mm = {64'd0, m};
    base = {64'd0, x} % mm;
    res = 128'd1 % mm;
    ee = e;
    while (ee != '0) begin
      if (ee[0]) res = (res * base) % mm;
      base = (base * base) % mm;
      ee = ee >> 1;
    end
    return res[63:0];
  endfunction

  function automatic int exp_ops(input logic [EXP_W-1:0] e);
    int pc;
    pc = $countones(e);
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
    begin
      int msb;
      msb = -1;
      for (int i = 0; i < EXP_W; i++) if (e[i]) msb = i;
      return 3 + (msb + 1) + pc;
    end
`else
    return 3 + EXP_W + pc;
`endif
  endfunction

  // Multiplier model: ready after lat_cur edges of mm_go, held until go drops.
  // Upper product bits are set to junk that the sequencer must ignore.
  always @(posedge pclk) begin
    if (!mm_go) begin
      mm_ready <= 1'b0;
      mm_p     <= '0;
      lat_cnt  <= 0;
      lat_cur  <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
    end else if (!mm_ready) begin
      if (lat_cnt + 1 >= lat_cur) begin
        mm_ready <= 1'b1;
        mm_p     <= {2'b01, mont(mm_a, mm_b, mm_m)};
      end
      lat_cnt <= lat_cnt + 1;
    end
  end

  // Handshake monitor: operand stability, go held until ready, exactly one
  // low cycle between ops, mm_m equal to the requested modulus while busy.
  always @(negedge pclk) begin
    if (reset) begin
      prev_go <= 1'b0;
      prev_ready <= 1'b0;
      in_op <= 1'b0;
      gap <= 0;
    end else begin
      if (mm_go && prev_go && (mm_a !== prev_a || mm_b !== prev_b)) prot_err <= prot_err + 1;
      if (!mm_go && prev_go && !prev_ready) prot_err <= prot_err + 1;
      if (mm_go && !prev_go) begin
        go_edges <= go_edges + 1;
        if (in_op && gap != 1) prot_err <= prot_err + 1;
      end
      if (busy && mm_m !== exp_m) prot_err <= prot_err + 1;
      if (done && busy) prot_err <= prot_err + 1;
      gap <= mm_go ? 0 : gap + 1;
      if (done) in_op <= 1'b0;
      else if (!mm_go && prev_go) in_op <= 1'b1;
      prev_go <= mm_go;
      prev_ready <= mm_ready;
      prev_a <= mm_a;
      prev_b <= mm_b;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] x, input logic [EXP_W-1:0] e, input logic [63:0] m,
                        input int inject_at, output logic [63:0] res, output int cycles,
                        output int ops, output logic busy_ok, output logic done_next,
                        output logic [63:0] res_next, output logic to);
    int g0;
    @(posedge pclk); #1;
    x_in = x; e_in = e; m_in = m; r2_in = r2_of(m); exp_m = m; start = 1'b1;
    g0 = go_edges;
    @(posedge pclk); #1;
    start = 1'b0;
    cycles = 1; busy_ok = 1'b1; to = 1'b1; res = '0;
    for (int k = 0; k < 5000; k++) begin
      cycles++;
      if (cycles == inject_at) begin
        // a second request with different operands while busy
        start = 1'b1; x_in = ~x; e_in = ~e; m_in = m ^ 64'h10; r2_in = 64'h5;
      end else begin
        start = 1'b0;
      end
      @(negedge pclk);
      if (done) begin
        to = 1'b0;
        res = result;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge pclk); #1;
    end
    start = 1'b0;
    ops = go_edges - g0;
    @(posedge pclk); #1;
    @(negedge pclk);
    done_next = done;
    res_next = result;
  endtask

  task automatic do_case(input string tag, input logic [63:0] x, input logic [EXP_W-1:0] e,
                         input logic [63:0] m, input logic [63:0] exp_res, input int inject_at);
    logic [63:0] res, res_next;
    int cycles, ops;
    logic busy_ok, done_next, to;
    run_op(x, e, m, inject_at, res, cycles, ops, busy_ok, done_next, res_next, to);
    $display("op %s x=%0h e=%0h m=%0h result=%0h ops=%0d cycles=%0d", tag, x, e, m, res, ops, cycles);
    check($sformatf("%s timeout", tag), 64'(to), 64'd0);
    check($sformatf("%s result", tag), res, exp_res);
    check($sformatf("%s ops", tag), 64'(ops), 64'(exp_ops(e)));
    check($sformatf("%s busy", tag), 64'(busy_ok), 64'd1);
    check($sformatf("%s done_pulse", tag), 64'(done_next), 64'd0);
    check($sformatf("%s held", tag), res_next, exp_res);
    check($sformatf("%s protocol", tag), 64'(prot_err), 64'd0);
    // each op: (fixed_lat+1) cycles with go high plus one gap; +accept +done
    if (fixed_lat != 0)
      check($sformatf("%s cycles", tag), 64'(cycles), 64'(exp_ops(e) * (fixed_lat + 2) + 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m, x;
    logic [EXP_W-1:0] e;
    int g0;
    logic hit;

    reset = 1'b1; start = 1'b0; x_in = '0; e_in = '0; m_in = '0; r2_in = '0;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;
    @(negedge pclk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset mm_go", 64'(mm_go), 64'd0);
    check("reset result", result, 64'd0);
    check("reset mm_m", mm_m, 64'd0);
    check("r2 of 23", r2_of(64'd23), 64'd13);

    do_case("x5e3", 64'd5, 8'd3, 64'd23, 64'd10, 0);
    do_case("ignored_start", 64'd5, 8'd3, 64'd23, 64'd10, 10);
    do_case("fermat", 64'd5, 8'd22, 64'd23, 64'd1, 0);
    do_case("e_zero", 64'd5, 8'd0, 64'd23, 64'd1, 0);
    do_case("x_zero", 64'd0, 8'd5, 64'd23, 64'd0, 0);
    fixed_lat = 2;
    do_case("fixed_lat", 64'd5, 8'd3, 64'd23, 64'd10, 0);
    fixed_lat = 0;
    do_case("x22e1", 64'd22, 8'd1, 64'd23, 64'd22, 0);

    // reset while the first SQR op is in progress
    fixed_lat = 4;
    @(posedge pclk); #1;
    x_in = 64'd5; e_in = 8'd3; m_in = 64'd23; r2_in = 64'd13; exp_m = 64'd23; start = 1'b1;
    g0 = go_edges;
    @(posedge pclk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge pclk);
      if ((go_edges - g0) >= 3 && mm_go === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach sqr", 64'(hit), 64'd1);
    @(posedge pclk); #1 reset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    $display("abort busy=%0b done=%0b mm_go=%0b result=%0h mm_m=%0h", busy, done, mm_go, result, mm_m);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort mm_go", 64'(mm_go), 64'd0);
    check("abort result", result, 64'd0);
    check("abort mm_m", mm_m, 64'd0);
    @(posedge pclk); #1 reset = 1'b0;
    fixed_lat = 0;
    do_case("after_abort", 64'd5, 8'd3, 64'd23, 64'd10, 0);

    for (int i = 0; i < 10; i++) begin
      if (i < 4) m = 64'($urandom_range(3, 999)) | 64'd1;
      else m = {$urandom, $urandom} | 64'd1;
      if (m < 64'd3) m = 64'd3;
      x = {$urandom, $urandom} % m;
      e = EXP_W'($urandom);
      do_case($sformatf("rand%0d", i), x, e, m, ref_exp(x, e, m), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
